// File: rtl/serv_dbus_pkg.sv
// Shared encodings for the SERV data-bus controller: access sizes, FSM states
// and the default bus timeout.
package serv_dbus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/serv_dbus_ctrl_if.sv
// Wishbone classic data port of the SERV data-bus controller; the controller
// is the master, the memory/peripheral side is the slave.
interface serv_dbus_ctrl_if;

    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;

    modport master (
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        input  i_wb_rdt, i_wb_ack
    );

    modport slave (
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        output i_wb_rdt, i_wb_ack
    );

endinterface

// File: rtl/serv_dbus_sel.sv
// Combinational byte-enable and misalignment decode for a (size, adr[1:0])
// pair; reserved size 3 decodes as a word access.
module serv_dbus_sel
    import serv_dbus_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] adr,
    output logic [3:0] sel,
    output logic       misalign
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        sel      = 4'b1111;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: sel = 4'b0001 << adr;
            SZ_HALF: begin
                sel      = adr[1] ? 4'b1100 : 4'b0011;
                misalign = adr[0];
            end
            default: misalign = |adr;
        endcase
    end

endmodule

// File: rtl/serv_dbus_ctrl.sv
// SERV data-bus transaction controller: one Wishbone classic cycle per request.
// Optional hung-cycle abort is enabled with `define SERV_DBUS_TIMEOUT_EN.
module serv_dbus_ctrl
    import serv_dbus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int TO_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic             i_we,
    input  logic [1:0]       i_size,
    input  logic [31:0]      i_adr,
    input  logic [31:0]      i_wdat,
    output logic             o_busy,
    output logic             o_ack,
    output logic             o_misalign,
    output logic             o_err,
    output logic             o_load,
    output logic [31:0]      o_rdat,
    serv_dbus_ctrl_if.master wb
);

    state_e     state;
    logic [3:0] sel;
    logic       misalign;
    logic       accept;
    logic       to_hit;

    serv_dbus_sel u_sel (
        .size     (i_size),
        .adr      (i_adr[1:0]),
        .sel      (sel),
        .misalign (misalign)
    );

    // LOAD is the completion cycle, so it takes a new request just like IDLE.
    assign accept = i_req && (state != ST_BUS) && !misalign;

`ifdef SERV_DBUS_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            to_cnt <= '0;
        else if (state != ST_BUS)
            to_cnt <= '0;
        else if (!wb.i_wb_ack)
            to_cnt <= to_cnt + 1'b1;
    end

    assign to_hit = (to_cnt == TO_W'(TIMEOUT));
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT, TO_W};
    assign to_hit     = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            o_busy      <= 1'b0;
            o_ack       <= 1'b0;
            o_misalign  <= 1'b0;
            o_err       <= 1'b0;
            o_load      <= 1'b0;
            o_rdat      <= '0;
            wb.o_wb_adr <= '0;
            wb.o_wb_dat <= '0;
            wb.o_wb_sel <= '0;
            wb.o_wb_we  <= 1'b0;
            wb.o_wb_cyc <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            o_ack      <= 1'b0;
            o_misalign <= 1'b0;
            o_err      <= 1'b0;
            o_load     <= 1'b0;
            o_busy     <= accept || (state == ST_BUS);
            case (state)
                ST_BUS: begin
                    if (wb.i_wb_ack) begin
                        wb.o_wb_cyc <= 1'b0;
                        o_ack       <= 1'b1;
                        if (wb.o_wb_we) begin
                            state <= ST_IDLE;
                        end else begin
                            o_rdat <= wb.i_wb_rdt;
                            o_load <= 1'b1;
                            state  <= ST_LOAD;
                        end
                    end else if (to_hit) begin
                        wb.o_wb_cyc <= 1'b0;
                        o_ack       <= 1'b1;
                        o_err       <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    if (i_req && misalign) begin
                        o_misalign <= 1'b1;
                    end else if (accept) begin
                        wb.o_wb_adr <= {i_adr[31:2], 2'b00};
                        wb.o_wb_dat <= i_wdat;
                        wb.o_wb_sel <= sel;
                        wb.o_wb_we  <= i_we;
                        wb.o_wb_cyc <= 1'b1;
                        state       <= ST_BUS;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/serv_dbus_ctrl.md
Name: serv_dbus_ctrl

Overview:
Data-bus transaction controller between the shift/load buffer register and the external Wishbone data port.
- Takes a store image (already byte-positioned by the buffer register) plus the address and access size from the core.
- Runs one Wishbone classic cycle per request.
- On reads, returns the fetched word as a one-cycle load pulse that the buffer register latches in parallel.
- Detects misaligned accesses and, optionally, times out hung cycles.

Parameters:
TIMEOUT, 255, bus cycles in BUS before abort (only with SERV_DBUS_TIMEOUT_EN); legal range 1..65535.
TO_W, 8, timeout counter width; must satisfy 2**TO_W > TIMEOUT.

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  reset, asynchronous, active-high
i_req  in  1  single-cycle transaction request from core control
i_we  in  1  1=store, 0=load; sampled with i_req
i_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
i_adr  in  32  byte address; sampled with i_req
i_wdat  in  32  store image from buffer register, sampled with i_req
o_busy  out  1  high from the cycle after an accepted i_req until the cycle after o_ack
o_ack  out  1  one-cycle completion pulse to core
o_misalign  out  1  one-cycle pulse: request rejected, no bus cycle issued
o_err  out  1  one-cycle timeout pulse (0 when feature off)
o_load  out  1  one-cycle parallel-load strobe to buffer register
o_rdat  out  32  captured read word, valid while o_load=1, held otherwise
o_wb_adr  out  32  {adr[31:2],2'b00}
o_wb_dat  out  32  registered i_wdat
o_wb_sel  out  4  byte enables
o_wb_we  out  1  write enable
o_wb_cyc  out  1  cycle/strobe (single combined signal)
i_wb_rdt  in  32  read data
i_wb_ack  in  1  cycle acknowledge

Behaviour:
Reset values:
- FSM=IDLE.
- o_wb_cyc, o_ack, o_load, o_misalign, o_err, o_busy = 0.
- o_rdat, o_wb_adr, o_wb_dat, o_wb_sel = 0; o_wb_we = 0.
- Reset asserted mid-cycle drops o_wb_cyc immediately (asynchronous); no o_ack follows.

Byte-enable decode:
- byte: sel=4'b0001<<adr[1:0].
- half: sel = adr[1] ? 1100 : 0011.
- word: sel=1111.
- Misaligned: half with adr[0]=1; word with adr[1:0]!=0.

FSM states: IDLE, BUS, LOAD.
- IDLE, i_req and misaligned: o_misalign=1 next cycle; stay IDLE; no bus activity.
- IDLE, i_req and aligned: register adr/sel/we/wdat; go to BUS; o_wb_cyc=1 from the next cycle.
- BUS: o_wb_cyc held high with adr/sel/we/dat stable until i_wb_ack.
  - Ack on a write: o_wb_cyc=0 and o_ack=1 next cycle; go to IDLE.
  - Ack on a read: o_rdat<=i_wb_rdt; go to LOAD.
- LOAD: o_load=1 and o_ack=1 for exactly one cycle; o_wb_cyc=0; go to IDLE.

Timing and boundary rules:
- Minimum latency (ack in the first BUS cycle): req@T0, cyc@T1, ack@T1, o_ack@T2 for both reads and writes.
- i_req while not IDLE is ignored (no queueing).
- i_req is accepted in the same cycle o_ack is high, because FSM is already IDLE.
- i_wb_ack outside BUS is ignored.
- o_rdat is unchanged on writes and on misaligned or timed-out requests.

Optional Feature:
SERV_DBUS_TIMEOUT_EN.
- Defined:
  - TO_W-bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - On reaching TIMEOUT: o_wb_cyc=0 next cycle, o_err=1 and o_ack=1 for one cycle, no o_load; go to IDLE.
  - Ack in the same cycle the count reaches TIMEOUT: ack wins, normal completion, no o_err.
- Undefined: counter absent, o_err tied 0, BUS waits indefinitely.

Decomposition:
- Package serv_dbus_pkg holds:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - FSM state encodings ST_IDLE, ST_BUS, ST_LOAD;
  - TIMEOUT default.
- One sub-module: serv_dbus_sel, a combinational decode of (size, adr[1:0]) to (sel[3:0], misalign), shared with any future instruction-bus controller.

Test Plan:
1. Store word, adr=0x1000, wdat=0xDEADBEEF, ack in the first BUS cycle -> cyc@T1 with adr=0x1000, sel=1111, we=1, dat=0xDEADBEEF; o_ack@T2; o_load never high.
2. Load byte, adr=0x2003, ack after 3 wait cycles with rdt=0x11223344 -> sel=1000; o_load=o_ack=1 for one cycle; o_rdat=0x11223344.
3. Half at adr=0x3001 and word at adr=0x3002 -> o_misalign pulse each, o_wb_cyc stays 0, o_busy stays 0.
4. i_req pulsed during BUS and i_wb_ack pulsed in IDLE -> no second cycle issued, no spurious o_ack/o_load.
5. i_rst asserted mid-BUS -> o_wb_cyc falls asynchronously; after release FSM=IDLE, o_rdat=0, no o_ack.
6. With SERV_DBUS_TIMEOUT_EN and TIMEOUT=4, no ack -> o_err=o_ack=1 once and cyc drops; ack in the expiry cycle -> normal o_ack, o_err=0.
